mem_access_sync: RTL and testbench
==================================

Name: mem_access_sync

Overview:
- N-channel memory handshake synchroniser for the pipelined RV32 core; generalises the fixed IM/DM two-port done-tracking FSM to NUM_CH channels.
- Issues per-channel read/write strobes, latches each channel's completion, holds a global memory-access stall until every active channel has completed, then releases all channels together.
- Adds a wait-timeout error flag and an abort path for pipeline flush. Sits between the pipeline controller and the instruction/data cache ports.

Parameters:
- NUM_CH, 2, number of memory channels (ch0 = IM, ch1 = DM, more for extra ports); range 1..8.
- TO_W, 8, width of the wait-timeout counter.
- TO_CYCLES, 200, consecutive WAIT cycles before timeout_err sets; 0 disables the timeout.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- req_rd  in  NUM_CH  per-channel read request, level, held by the pipeline while stalled.
- req_wmask  in  4*NUM_CH  per-channel byte write mask; channel i uses bits [4i+3:4i]; non-zero means write.
- valid  in  NUM_CH  per-channel completion from the cache, 1-cycle pulse or level.
- abort  in  1  flush; discards latched completions.
- err_clr  in  1  clears timeout_err.
- mem_r  out  NUM_CH  read strobe to the cache.
- mem_w  out  4*NUM_CH  write byte mask to the cache.
- stall_ma  out  1  global stall.
- done_vec  out  NUM_CH  per-channel effective done.
- busy  out  1  FSM is in WAIT.
- timeout_err  out  1  sticky timeout flag.
- perf_stall_cnt  out  32*NUM_CH  per-channel stall counters; see Optional Feature.

Behaviour:
- Per channel i:
  - need[i] = req_rd[i] | (|req_wmask[i]).
  - done_vec[i] = ~need[i] | valid[i] | lat[i].
- all_done = &done_vec.
- stall_ma = ~all_done. This path is combinational with no added latency; the release cycle is the same cycle the last valid arrives.
- mem_r[i] = req_rd[i] & ~lat[i].
- mem_w[i] = lat[i] ? 4'b0 : req_wmask[i].
- A channel that has completed stops re-requesting while its siblings are still waiting.
- Latch update at each clk edge:
  - all_done=1: lat cleared to 0.
  - Otherwise: lat[i] <= lat[i] | (valid[i] & need[i]).
  - A valid on a channel with need=0 is ignored and is never latched.
- FSM, 2 states, encoding 1'b0 / 1'b1:
  - IDLE: entered from reset. If all_done=1, stay in IDLE. If all_done=0, go to WAIT.
  - WAIT: if all_done=1, go to IDLE. Otherwise stay in WAIT.
  - busy = (state==WAIT).
- Timeout counter to_cnt (TO_W bits):
  - Cleared in IDLE and on abort.
  - Increments each WAIT cycle with all_done=0, saturating at all-ones.
  - When to_cnt == TO_CYCLES-1 and all_done=0, timeout_err sets on the next edge.
  - timeout_err is sticky until err_clr=1. A set and a clear in the same cycle resolve as set.
  - The FSM keeps waiting after a timeout; the flag is report-only.
- abort=1 at an edge: lat<=0, to_cnt<=0, state<=IDLE. Outputs in the abort cycle itself are unaffected, since they are combinational on current inputs.
- Simultaneous events:
  - Last outstanding valid and an earlier latch in the same cycle: all_done=1, no latch taken, return to IDLE.
  - All valids arriving in the first request cycle: stall_ma stays 0 and the FSM stays in IDLE.
- Reset, including mid-WAIT: state=IDLE, lat=0, to_cnt=0, timeout_err=0, perf counters=0.
- Outputs immediately after reset follow the combinational rules above with lat=0.

Optional Feature:
- Macro MEM_SYNC_PERF_CNT_EN.
- Defined:
  - perf_stall_cnt[i] is a 32-bit counter that increments on each cycle with stall_ma=1 and need[i]=1 and done_vec[i]=0. This counts cycles where channel i is the blocker.
  - Wraps at 2^32.
  - Cleared by rst and by err_clr.
- Undefined: perf_stall_cnt is tied to 0, the port is still present, and no counter flops are inferred.

Decomposition:
- Shared define file mem_sync_define.v:
  - FSM state encodings S_IDLE and S_WAIT.
  - Channel index constants CH_IM=0 and CH_DM=1.
- Sub-module mem_ch_tracker holds one channel: need/done/lat logic plus the optional perf counter. It is instantiated NUM_CH times in a generate loop.
- The FSM, timeout counter and all_done reduction stay in the top level.

Test Plan (NUM_CH=2, TO_CYCLES=4):
- Idle: req_rd=00, req_wmask=0 for 10 cycles -> stall_ma=0, mem_r=00, mem_w=0, busy=0 throughout.
- Staggered completion: req_rd[0]=1 and req_wmask[1]=4'b0011 from cycle 0, valid[0] pulse at cycle 2, valid[1] pulse at cycle 5.
  - stall_ma=1 in cycles 0-4, 0 in cycle 5.
  - mem_r[0]=0 in cycles 3-4.
  - mem_w[1]=0011 in cycles 0-5.
  - busy=1 in cycles 1-5; lat=00 by cycle 6.
- Same-cycle completion: both channels request, valid=11 at cycle 0 -> stall_ma never 1, busy stays 0.
- Timeout: req_rd[0]=1 with valid never asserted.
  - timeout_err=1 from cycle 5 and held for 10 further cycles.
  - Pulse err_clr -> timeout_err=0 on the next cycle, while busy remains 1.
- Abort mid-wait: ch0 latched at cycle 2, ch1 still pending, abort at cycle 3.
  - Cycle 4: busy=0, lat=00, mem_r[0]=1 again (req still held).
  - stall_ma=1 again while ch1 is outstanding.
- Reset mid-wait plus perf (MEM_SYNC_PERF_CNT_EN defined):
  - 3 stall cycles blocked on ch1 -> perf_stall_cnt[63:32]=3.
  - Assert rst asynchronously -> all counters 0, busy=0, timeout_err=0 immediately.

Source files
------------

// File: rtl/mem_access_sync_pkg.sv
// Shared types and constants for the memory handshake synchroniser.
// State encodings, channel indices and the small write-detect helper.
package mem_access_sync_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    localparam int CH_IM  = 0;
    localparam int CH_DM  = 1;
    localparam int PERF_W = 32;

    function automatic logic is_write(input logic [3:0] mask);
        return |mask;
    endfunction

endpackage

// File: rtl/mem_ch_tracker.sv
// One channel of the memory handshake synchroniser: need/done/latch logic.
// Optional per-channel blocker counter under MEM_SYNC_PERF_CNT_EN.
module mem_ch_tracker
    import mem_access_sync_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              req_rd,
    input  logic [3:0]        req_wmask,
    input  logic              valid,
    input  logic              all_done,
    input  logic              abort,
    input  logic              err_clr,
    output logic              done,
    output logic              mem_r,
    output logic [3:0]        mem_w,
    output logic [PERF_W-1:0] perf_cnt
);

    logic need;
    logic lat;

    assign need  = req_rd | is_write(req_wmask);
    assign done  = ~need | valid | lat;
    assign mem_r = req_rd & ~lat;
    assign mem_w = lat ? 4'b0000 : req_wmask;

    // A completion only sticks while its channel actually has a request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat <= 1'b0;
        end else if (abort || all_done) begin
            lat <= 1'b0;
        end else begin
            lat <= lat | (valid & need);
        end
    end

`ifdef MEM_SYNC_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_cnt <= '0;
        end else if (err_clr) begin
            perf_cnt <= '0;
        end else if (~all_done && need && ~done) begin
            perf_cnt <= perf_cnt + 1'b1;
        end
    end
`else
    logic unused_perf;
    assign unused_perf = err_clr;
    assign perf_cnt    = '0;
`endif

endmodule

// File: rtl/mem_access_sync.sv
// N-channel memory handshake synchroniser: holds stall_ma until every active
// channel completes. Perf counters are built only with MEM_SYNC_PERF_CNT_EN.
module mem_access_sync
    import mem_access_sync_pkg::*;
#(
    parameter int NUM_CH    = 2,
    parameter int TO_W      = 8,
    parameter int TO_CYCLES = 200
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_CH-1:0]      req_rd,
    input  logic [4*NUM_CH-1:0]    req_wmask,
    input  logic [NUM_CH-1:0]      valid,
    input  logic                   abort,
    input  logic                   err_clr,
    output logic [NUM_CH-1:0]      mem_r,
    output logic [4*NUM_CH-1:0]    mem_w,
    output logic                   stall_ma,
    output logic [NUM_CH-1:0]      done_vec,
    output logic                   busy,
    output logic                   timeout_err,
    output logic [32*NUM_CH-1:0]   perf_stall_cnt
);

    localparam logic            TO_EN   = (TO_CYCLES != 0);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((TO_CYCLES == 0) ? 0 : TO_CYCLES - 1);

    state_t          state;
    logic [TO_W-1:0] to_cnt;
    logic            all_done;
    logic            to_hit;

    assign all_done = &done_vec;
    assign stall_ma = ~all_done;
    assign busy     = (state == S_WAIT);
    assign to_hit   = TO_EN && (state == S_WAIT) && !all_done && (to_cnt == TO_LAST);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        mem_ch_tracker u_trk (
            .clk       (clk),
            .rst       (rst),
            .req_rd    (req_rd[i]),
            .req_wmask (req_wmask[4*i +: 4]),
            .valid     (valid[i]),
            .all_done  (all_done),
            .abort     (abort),
            .err_clr   (err_clr),
            .done      (done_vec[i]),
            .mem_r     (mem_r[i]),
            .mem_w     (mem_w[4*i +: 4]),
            .perf_cnt  (perf_stall_cnt[32*i +: 32])
        );
    end

    // Timeout is report-only; the FSM keeps waiting after it fires.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            to_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (to_hit) begin
                timeout_err <= 1'b1;
            end else if (err_clr) begin
                timeout_err <= 1'b0;
            end
            if (abort) begin
                state  <= S_IDLE;
                to_cnt <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        to_cnt <= '0;
                        if (!all_done) state <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (all_done) begin
                            state  <= S_IDLE;
                            to_cnt <= '0;
                        end else if (to_cnt != '1) begin
                            to_cnt <= to_cnt + 1'b1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_access_sync.sv
// Directed bench for mem_access_sync (NUM_CH=2, TO_CYCLES=4) with an expected-value queue.
// Perf expectations follow MEM_SYNC_PERF_CNT_EN.
module tb_mem_access_sync;

    localparam int SEL_STALL = 0;
    localparam int SEL_MEMR  = 1;
    localparam int SEL_MEMW  = 2;
    localparam int SEL_BUSY  = 3;
    localparam int SEL_TERR  = 4;
    localparam int SEL_DONE  = 5;
    localparam int SEL_PERF  = 6;

`ifdef MEM_SYNC_PERF_CNT_EN
    localparam logic [31:0] PERF3 = 32'd3;
`else
    localparam logic [31:0] PERF3 = 32'd0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_rd;
    logic [7:0]  req_wmask;
    logic [1:0]  valid;
    logic        abort;
    logic        err_clr;
    logic [1:0]  mem_r;
    logic [7:0]  mem_w;
    logic        stall_ma;
    logic [1:0]  done_vec;
    logic        busy;
    logic        timeout_err;
    logic [63:0] perf_stall_cnt;

    typedef struct {
        string       tag;
        int          sel;
        logic [63:0] exp;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    mem_access_sync #(.NUM_CH(2), .TO_W(8), .TO_CYCLES(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_rd         (req_rd),
        .req_wmask      (req_wmask),
        .valid          (valid),
        .abort          (abort),
        .err_clr        (err_clr),
        .mem_r          (mem_r),
        .mem_w          (mem_w),
        .stall_ma       (stall_ma),
        .done_vec       (done_vec),
        .busy           (busy),
        .timeout_err    (timeout_err),
        .perf_stall_cnt (perf_stall_cnt)
    );

    function automatic logic [63:0] observe(input int sel);
        case (sel)
            SEL_STALL: return {63'd0, stall_ma};
            SEL_MEMR:  return {62'd0, mem_r};
            SEL_MEMW:  return {56'd0, mem_w};
            SEL_BUSY:  return {63'd0, busy};
            SEL_TERR:  return {63'd0, timeout_err};
            SEL_DONE:  return {62'd0, done_vec};
            default:   return perf_stall_cnt;
        endcase
    endfunction

    task automatic push(input string tag, input int sel, input logic [63:0] v);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic check_pending();
        exp_t        e;
        logic [63:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.sel);
            total++;
            assert (obs === e.exp) else begin
                bad++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        check_pending();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] rd, input logic [7:0] wm, input logic [1:0] v,
                         input logic ab, input logic ec);
        req_rd    = rd;
        req_wmask = wm;
        valid     = v;
        abort     = ab;
        err_clr   = ec;
    endtask

    initial begin
        rst = 1'b1;
        drive(2'b00, 8'h00, 2'b00, 1'b0, 1'b0);
        push("rst_stall", SEL_STALL, 0);
        push("rst_busy",  SEL_BUSY,  0);
        push("rst_terr",  SEL_TERR,  0);
        push("rst_memr",  SEL_MEMR,  0);
        push("rst_perf",  SEL_PERF,  0);
        step();
        rst = 1'b0;

        for (int k = 0; k < 10; k++) begin
            drive(2'b00, 8'h00, 2'b00, 1'b0, 1'b0);
            push("idle_stall", SEL_STALL, 0);
            push("idle_memr",  SEL_MEMR,  0);
            push("idle_memw",  SEL_MEMW,  0);
            push("idle_busy",  SEL_BUSY,  0);
            step();
        end

        // Staggered completion: ch0 read, ch1 write 0011.
        for (int c = 0; c <= 6; c++) begin
            drive(2'b01, 8'h30, (c == 2) ? 2'b01 : ((c == 5) ? 2'b10 : 2'b00), 1'b0, 1'b0);
            push("stag_stall", SEL_STALL, (c == 5) ? 0 : 1);
            push("stag_memr",  SEL_MEMR,  (c == 3 || c == 4 || c == 5) ? 0 : 1);
            push("stag_memw",  SEL_MEMW,  64'h30);
            push("stag_busy",  SEL_BUSY,  (c >= 1 && c <= 5) ? 1 : 0);
            if (c == 3) push("stag_done", SEL_DONE, 2'b01);
            if (c == 5) push("stag_terr", SEL_TERR, 1);
            if (c == 6) push("stag_lat_clr", SEL_DONE, 2'b00);
            step();
        end
        drive(2'b00, 8'h00, 2'b00, 1'b0, 1'b0);
        push("stag_drop_busy", SEL_BUSY, 1);
        push("stag_drop_stall", SEL_STALL, 0);
        step();
        drive(2'b00, 8'h00, 2'b00, 1'b0, 1'b1);
        push("stag_idle_busy", SEL_BUSY, 0);
        push("stag_clr_terr_hold", SEL_TERR, 1);
        step();
        drive(2'b00, 8'h00, 2'b00, 1'b0, 1'b0);
        push("stag_clr_terr", SEL_TERR, 0);
        push("stag_clr_perf", SEL_PERF, 0);
        step();

        // Same-cycle completion on both channels.
        drive(2'b01, 8'h30, 2'b11, 1'b0, 1'b0);
        push("same_stall", SEL_STALL, 0);
        push("same_busy",  SEL_BUSY,  0);
        push("same_done",  SEL_DONE,  2'b11);
        step();
        drive(2'b00, 8'h00, 2'b00, 1'b0, 1'b0);
        push("same_busy_after", SEL_BUSY, 0);
        step();

        // Timeout with ch0 never completing.
        for (int k = 0; k <= 15; k++) begin
            drive(2'b01, 8'h00, 2'b00, 1'b0, 1'b0);
            push("to_stall", SEL_STALL, 1);
            push("to_busy",  SEL_BUSY,  (k == 0) ? 0 : 1);
            push("to_terr",  SEL_TERR,  (k >= 5) ? 1 : 0);
            step();
        end
        drive(2'b01, 8'h00, 2'b00, 1'b0, 1'b1);
        push("to_clr_cycle", SEL_TERR, 1);
        step();
        drive(2'b01, 8'h00, 2'b00, 1'b0, 1'b0);
        push("to_cleared", SEL_TERR, 0);
        push("to_still_busy", SEL_BUSY, 1);
        step();
        drive(2'b00, 8'h00, 2'b00, 1'b0, 1'b0);
        push("to_drop_stall", SEL_STALL, 0);
        step();
        push("to_idle_busy", SEL_BUSY, 0);
        step();

        // Abort mid-wait with ch0 latched and ch1 pending.
        drive(2'b11, 8'h00, 2'b00, 1'b0, 1'b0);
        push("ab_c0_memr", SEL_MEMR, 2'b11);
        push("ab_c0_busy", SEL_BUSY, 0);
        step();
        push("ab_c1_busy", SEL_BUSY, 1);
        step();
        drive(2'b11, 8'h00, 2'b01, 1'b0, 1'b0);
        push("ab_c2_memr", SEL_MEMR, 2'b11);
        push("ab_c2_done", SEL_DONE, 2'b01);
        step();
        drive(2'b11, 8'h00, 2'b00, 1'b1, 1'b0);
        push("ab_c3_memr",  SEL_MEMR,  2'b10);
        push("ab_c3_busy",  SEL_BUSY,  1);
        push("ab_c3_stall", SEL_STALL, 1);
        step();
        drive(2'b11, 8'h00, 2'b00, 1'b0, 1'b0);
        push("ab_c4_busy",  SEL_BUSY,  0);
        push("ab_c4_memr",  SEL_MEMR,  2'b11);
        push("ab_c4_done",  SEL_DONE,  2'b00);
        push("ab_c4_stall", SEL_STALL, 1);
        step();
        drive(2'b11, 8'h00, 2'b10, 1'b0, 1'b0);
        push("ab_c5_done",  SEL_DONE,  2'b10);
        push("ab_c5_stall", SEL_STALL, 1);
        step();
        drive(2'b11, 8'h00, 2'b01, 1'b0, 1'b0);
        push("ab_c6_stall", SEL_STALL, 0);
        push("ab_c6_memr",  SEL_MEMR,  2'b01);
        step();
        drive(2'b00, 8'h00, 2'b00, 1'b0, 1'b0);
        push("ab_end_stall", SEL_STALL, 0);
        step();
        push("ab_end_busy", SEL_BUSY, 0);
        step();

        // Perf counter blocked on ch1, then async reset mid-wait.
        drive(2'b00, 8'h00, 2'b00, 1'b0, 1'b1);
        step();
        drive(2'b00, 8'h00, 2'b00, 1'b0, 1'b0);
        push("perf_pre", SEL_PERF, 0);
        step();
        for (int c = 0; c < 3; c++) begin
            drive(2'b10, 8'h00, 2'b00, 1'b0, 1'b0);
            push("perf_stall", SEL_STALL, 1);
            step();
        end
        push("perf_cnt3", SEL_PERF, {PERF3, 32'd0});
        push("perf_busy", SEL_BUSY, 1);
        @(negedge clk);
        check_pending();
        #1 rst = 1'b1;
        #1;
        push("arst_busy",  SEL_BUSY,  0);
        push("arst_terr",  SEL_TERR,  0);
        push("arst_perf",  SEL_PERF,  0);
        push("arst_stall", SEL_STALL, 1);
        push("arst_memr",  SEL_MEMR,  2'b10);
        check_pending();
        @(posedge clk);
        #1 rst = 1'b0;
        drive(2'b00, 8'h00, 2'b00, 1'b0, 1'b0);
        push("post_busy", SEL_BUSY, 0);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
